// File: rtl/led_blink_ctrl.sv
// -----------------------------------------------------------------------------
// led_blink_ctrl
//   Multi-channel LED driver. Each channel is independently configured as
//   off, on, blink (software-set half period counted in prescaler ticks) or
//   PWM (duty compare against a free-running counter).
//
//   Optional feature macro: LED_PWM_EN
//     defined   : PWM mode, per-channel duty registers and pwm_cnt present.
//     undefined : no duty registers or pwm_cnt, cfg_duty is ignored and
//                 mode 11 drives the LED on, exactly like mode 01.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   asynchronous, active-high reset
//   cfg_we       in   configuration write strobe (single-cycle pulse)
//   cfg_idx      in   channel addressed by the write
//   cfg_mode     in   00 off, 01 on, 10 blink, 11 pwm
//   cfg_half     in   blink half period in ticks, minus one
//   cfg_duty     in   PWM duty value
//   cfg_ack      out  one-cycle pulse the cycle after an accepted write
//   sync_restart in   clears blink phase of every channel
//   led          out  registered LED drive, bit i = channel i
//
// Handshake: a write is accepted when cfg_we=1 and cfg_idx addresses an
// existing channel; there is no back-pressure, so cfg_ack only reports that
// the write landed. Out-of-range writes are dropped silently (no ack).
// -----------------------------------------------------------------------------
module led_blink_ctrl #(
  parameter int NB_LEDS  = 8,
  parameter int CNT_MAX  = 999999,
  parameter int PWM_BITS = 4,
  localparam int IDX_W   = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [1:0]          cfg_mode,
  input  logic [7:0]          cfg_half,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_ack,
  input  logic                sync_restart,
  output logic [NB_LEDS-1:0]  led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  localparam int PS_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [PS_W-1:0]  PS_MAX = PS_W'(CNT_MAX);
  // One extra bit so NB_LEDS itself is representable for the range compare.
  localparam logic [IDX_W:0]   NB_CMP = (IDX_W + 1)'(NB_LEDS);

  // ---------------------------------------------------------------------------
  // Tick prescaler: tick is high for the single cycle where the count sits at
  // its terminal value, giving one tick every CNT_MAX+1 cycles.
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] presc;
  logic            tick;

  assign tick = (presc == PS_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic               wr_ok;
  logic [NB_LEDS-1:0] wr_sel;

  assign wr_ok = cfg_we && ({1'b0, cfg_idx} < NB_CMP);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      wr_sel[i] = wr_ok && (cfg_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel configuration registers
  // ---------------------------------------------------------------------------
  mode_t      mode_q [NB_LEDS];
  logic [7:0] half_q [NB_LEDS];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NB_LEDS; i++) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_LEDS; i++) begin
        if (wr_sel[i]) begin
          mode_q[i] <= mode_t'(cfg_mode);
          half_q[i] <= cfg_half;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase. Restart (global or from a write to the channel) wins over a
  // coincident tick so the new phase always starts from a clean zero.
  // ---------------------------------------------------------------------------
  logic [7:0]         bcnt_q [NB_LEDS];
  logic [NB_LEDS-1:0] ph_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ph_q <= '0;
      for (int i = 0; i < NB_LEDS; i++) begin
        bcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_LEDS; i++) begin
        if (sync_restart || wr_sel[i] || (mode_q[i] != MODE_BLINK)) begin
          bcnt_q[i] <= '0;
          ph_q[i]   <= 1'b0;
        end else if (tick) begin
          if (bcnt_q[i] >= half_q[i]) begin
            bcnt_q[i] <= '0;
            ph_q[i]   <= ~ph_q[i];
          end else begin
            bcnt_q[i] <= bcnt_q[i] + 8'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM compare (only built with LED_PWM_EN)
  // ---------------------------------------------------------------------------
  logic [NB_LEDS-1:0] pwm_out;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q [NB_LEDS];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NB_LEDS; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_LEDS; i++) begin
        if (wr_sel[i]) begin
          duty_q[i] <= cfg_duty;
        end
      end
    end
  end

  // Strict less-than: duty 0 never lights, full-scale duty leaves one dark
  // slot per PWM period.
  always_comb begin
    pwm_out = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      pwm_out[i] = (pwm_cnt < duty_q[i]);
    end
  end
`else
  // Without PWM support mode 11 simply lights the LED.
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
  assign pwm_out     = '1;
`endif

  // ---------------------------------------------------------------------------
  // Registered LED output
  // ---------------------------------------------------------------------------
  logic [NB_LEDS-1:0] led_d;

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = ph_q[i];
        MODE_PWM:   led_d[i] = pwm_out[i];
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_blink_ctrl
//   Directed bench for led_blink_ctrl with NB_LEDS=5 (so out-of-range
//   indices 5..7 exist on the 3-bit cfg_idx), CNT_MAX=3, PWM_BITS=4.
//   Vector k is driven on a falling edge, consumed by rising edge P_k and its
//   expected outputs are compared on the next falling edge. A vector flagged
//   rst re-applies reset first, so k restarts at 0 with prescaler and PWM
//   counter at 0: ticks are consumed at P3, P7, P11, ... and pwm_cnt before
//   P_k is k mod 16.
// -----------------------------------------------------------------------------
module tb_led_blink_ctrl;

  localparam int NB  = 5;
  localparam int CM  = 3;
  localparam int PB  = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_half;
  logic [PB-1:0] cfg_duty;
  logic          cfg_ack;
  logic          sync_restart;
  logic [NB-1:0] led;

  int checks = 0;
  int errors = 0;

  led_blink_ctrl #(
    .NB_LEDS  (NB),
    .CNT_MAX  (CM),
    .PWM_BITS (PB)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_mode     (cfg_mode),
    .cfg_half     (cfg_half),
    .cfg_duty     (cfg_duty),
    .cfg_ack      (cfg_ack),
    .sync_restart (sync_restart),
    .led          (led)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            rst;
    bit            we;
    logic [2:0]    idx;
    logic [1:0]    mode;
    logic [7:0]    half;
    logic [PB-1:0] duty;
    bit            sync;
    logic [NB-1:0] exp_led;
    bit            exp_ack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit we, input logic [2:0] idx,
                     input logic [1:0] mode, input logic [7:0] half,
                     input logic [PB-1:0] duty, input bit sync,
                     input logic [NB-1:0] el, input bit ea);
    vec_t v;
    v.rst = rst; v.we = we; v.idx = idx; v.mode = mode; v.half = half;
    v.duty = duty; v.sync = sync; v.exp_led = el; v.exp_ack = ea;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic [NB-1:0] el);
    for (int i = 0; i < n; i++) begin
      add(1'b0, 1'b0, 3'd0, 2'b00, 8'd0, '0, 1'b0, el, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks / checker
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    cfg_we       = 1'b0;
    cfg_idx      = '0;
    cfg_mode     = '0;
    cfg_half     = '0;
    cfg_duty     = '0;
    sync_restart = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge where reset drops.
  task automatic do_reset();
    clear_inputs();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    sys_rst = 1'b1;
    clear_inputs();
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_ack", 32'(cfg_ack), 32'h0);

    // Blink ch1, half=0: LED toggles every tick (4 cycles); ph set at P3.
    add(1'b1, 1'b1, 3'd1, 2'b10, 8'd0, 4'd0, 1'b0, 5'h00, 1'b1);
    idle(3, 5'h00); idle(4, 5'h02); idle(4, 5'h00); idle(4, 5'h02);

    // Rewrite ch1 at P6 while lit: phase cleared there, P7 tick sets it again.
    add(1'b1, 1'b1, 3'd1, 2'b10, 8'd0, 4'd0, 1'b0, 5'h00, 1'b1);
    idle(3, 5'h00); idle(2, 5'h02);
    add(1'b0, 1'b1, 3'd1, 2'b10, 8'd0, 4'd0, 1'b0, 5'h02, 1'b1);
    idle(1, 5'h00); idle(4, 5'h02); idle(4, 5'h00);

    // Blink ch2, half=2: ph set at P11, so lit k12..k23. sync_restart at k19
    // lands on a tick and must cancel it: next set is at P31 (lit from k32).
    add(1'b1, 1'b1, 3'd2, 2'b10, 8'd2, 4'd0, 1'b0, 5'h00, 1'b1);
    idle(11, 5'h00); idle(7, 5'h04);
    add(1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 4'd0, 1'b1, 5'h04, 1'b0);
    idle(12, 5'h00); idle(2, 5'h04);

`ifdef LED_PWM_EN
    // PWM ch0 duty=5: led after P_k = (k%16 < 5) once mode is set.
    add(1'b1, 1'b1, 3'd0, 2'b11, 8'd0, 4'd5, 1'b0, 5'h00, 1'b1);
    idle(4, 5'h01); idle(11, 5'h00); idle(5, 5'h01); idle(11, 5'h00);
    // duty=0 at k32 (old duty still used for that edge), then dark.
    add(1'b0, 1'b1, 3'd0, 2'b11, 8'd0, 4'd0, 1'b0, 5'h01, 1'b1);
    idle(16, 5'h00);
    // duty=15 at k49: lit except when k%16 == 15 (k63).
    add(1'b0, 1'b1, 3'd0, 2'b11, 8'd0, 4'd15, 1'b0, 5'h00, 1'b1);
    idle(13, 5'h01); idle(1, 5'h00); idle(2, 5'h01);
`else
    // Without PWM support mode 11 on ch3 is steady on.
    add(1'b1, 1'b1, 3'd3, 2'b11, 8'd0, 4'd5, 1'b0, 5'h00, 1'b1);
    idle(20, 5'h08);
`endif

    // Index range: 5..7 dropped without ack, 4 (last channel) accepted.
    add(1'b1, 1'b1, 3'd1, 2'b01, 8'd0, 4'd0, 1'b0, 5'h00, 1'b1);
    idle(1, 5'h02);
    add(1'b0, 1'b1, 3'd5, 2'b01, 8'd0, 4'd0, 1'b0, 5'h02, 1'b0);
    add(1'b0, 1'b1, 3'd7, 2'b00, 8'd0, 4'd0, 1'b0, 5'h02, 1'b0);
    add(1'b0, 1'b1, 3'd6, 2'b10, 8'd0, 4'd0, 1'b0, 5'h02, 1'b0);
    idle(2, 5'h02);
    add(1'b0, 1'b1, 3'd4, 2'b01, 8'd0, 4'd0, 1'b0, 5'h02, 1'b1);
    idle(1, 5'h12);
    add(1'b0, 1'b1, 3'd1, 2'b00, 8'd0, 4'd0, 1'b0, 5'h12, 1'b1);
    idle(2, 5'h10);

    @(negedge sys_clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cfg_we       = vecs[i].we;
      cfg_idx      = vecs[i].idx;
      cfg_mode     = vecs[i].mode;
      cfg_half     = vecs[i].half;
      cfg_duty     = vecs[i].duty;
      sync_restart = vecs[i].sync;
      @(negedge sys_clk);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_ack", i), 32'(cfg_ack), 32'(vecs[i].exp_ack));
    end
    clear_inputs();

    // Asynchronous reset mid-blink and mid-write, then a write held during
    // reset must be discarded.
    do_reset();
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_mode = 2'b10; cfg_half = 8'd0;
    @(negedge sys_clk);
    clear_inputs();
    repeat (4) @(negedge sys_clk);
    check("async_pre_led", 32'(led), 32'h02);
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_mode = 2'b01;
    @(posedge sys_clk);
    #2;
    check("async_pre_ack", 32'(cfg_ack), 32'h1);
    sys_rst = 1'b1;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_ack", 32'(cfg_ack), 32'h0);
    @(negedge sys_clk);
    clear_inputs();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      check($sformatf("post_rst%0d_led", i), 32'(led), 32'h0);
      check($sformatf("post_rst%0d_ack", i), 32'(cfg_ack), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
